// File: rtl/needs_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | needs_pkg                                                          |
// | Shared stat indices, limits, FSM states and saturating helpers.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package needs_pkg;

    localparam int HUNGER    = 0;
    localparam int HAPPINESS = 1;
    localparam int HEALTH    = 2;
    localparam int HYGIENE   = 3;
    localparam int ENERGY    = 4;
    localparam int SOCIAL    = 5;
    localparam int NUM_STATS = 6;
    localparam int STAT_MAX  = 15;
    localparam int STAT_W    = 4;

    typedef logic [STAT_W-1:0] stat_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DECAY = 2'd1,
        ST_CARE  = 2'd2,
        ST_DEAD  = 2'd3
    } state_e;

    function automatic stat_t sat_inc(input stat_t v);
        return (v == stat_t'(STAT_MAX)) ? v : v + stat_t'(1);
    endfunction

    function automatic stat_t sat_sub(input stat_t v, input stat_t amt);
        return (v > amt) ? v - amt : '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_divider.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tick_divider                                                       |
// | Free-running 0..TICK_DIV-1 counter, one-cycle tick on the last.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tick_divider #(
    parameter int TICK_DIV = 1000000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == c_last);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/needs_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | needs_scheduler                                                    |
// | Periodic six-stat decay with care requests and a terminal state.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module needs_scheduler
    import needs_pkg::*;
#(
    parameter int TICK_DIV    = 1000000,
    parameter int CARE_AMOUNT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       action_valid,
    input  logic [2:0] action_sel,
    output logic       action_ready,
    output logic [3:0] hunger,
    output logic [3:0] happiness,
    output logic [3:0] health,
    output logic [3:0] hygiene,
    output logic [3:0] energy,
    output logic [3:0] social,
    output logic       busy,
    output logic       dead
);
    localparam stat_t      c_care     = stat_t'(CARE_AMOUNT);
    localparam logic [2:0] c_last_idx = 3'(NUM_STATS - 1);

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [2:0] sel_q, sel_d;
    logic       pend_q, pend_d;
    stat_t      stats_q [NUM_STATS];
    stat_t      stats_d [NUM_STATS];
    logic       tick_raw, tick, handshake;

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_raw)
    );

    // Ticks are ignored once dead so nothing can leave the terminal state.
    assign tick         = tick_raw && (state_q != ST_DEAD);
    assign action_ready = (state_q == ST_IDLE) && !tick && !pend_q;
    assign handshake    = action_valid && action_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sel_d   = sel_q;
        pend_d  = pend_q;
        stats_d = stats_q;
        case (state_q)
            ST_IDLE: begin
                if (tick || pend_q) begin
                    state_d = ST_DECAY;
                    idx_d   = '0;
                    pend_d  = 1'b0;
                end else if (handshake) begin
                    state_d = ST_CARE;
                    sel_d   = action_sel;
                end
            end
            ST_DECAY: begin
                stats_d[idx_q] = sat_inc(stats_q[idx_q]);
                if (tick) pend_d = 1'b1;
                if (idx_q == c_last_idx) begin
                    state_d = (stats_q[HUNGER] == stat_t'(STAT_MAX)) ? ST_DEAD : ST_IDLE;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            ST_CARE: begin
                // Selectors past the last stat are accepted as no-ops.
                if (sel_q <= c_last_idx) stats_d[sel_q] = sat_sub(stats_q[sel_q], c_care);
                if (tick) pend_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            sel_q   <= '0;
            pend_q  <= 1'b0;
            for (int i = 0; i < NUM_STATS; i++) stats_q[i] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            pend_q  <= pend_d;
            stats_q <= stats_d;
        end
    end

    assign busy      = (state_q == ST_DECAY) || (state_q == ST_CARE);
    assign dead      = (state_q == ST_DEAD);
    assign hunger    = stats_q[HUNGER];
    assign happiness = stats_q[HAPPINESS];
    assign health    = stats_q[HEALTH];
    assign hygiene   = stats_q[HYGIENE];
    assign energy    = stats_q[ENERGY];
    assign social    = stats_q[SOCIAL];

endmodule
`default_nettype wire

// File: tb/tb_needs_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_needs_scheduler                                                 |
// | Scenario tasks plus an event scoreboard checked at each busy fall. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_needs_scheduler;
    localparam int TICK_DIV    = 8;
    localparam int CARE_AMOUNT = 4;
    localparam logic [3:0] c_ev_decay = 4'd8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       action_valid = 1'b0;
    logic [2:0] action_sel = 3'd0;
    logic       action_ready, busy, dead;
    logic [3:0] hunger, happiness, health, hygiene, energy, social;

    needs_scheduler #(
        .TICK_DIV    (TICK_DIV),
        .CARE_AMOUNT (CARE_AMOUNT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .action_valid (action_valid),
        .action_sel   (action_sel),
        .action_ready (action_ready),
        .hunger       (hunger),
        .happiness    (happiness),
        .health       (health),
        .hygiene      (hygiene),
        .energy       (energy),
        .social       (social),
        .busy         (busy),
        .dead         (dead)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] sb [$];
    int         m_stats [6];
    bit         m_dead;
    int         tb_cnt, busy_run;
    bit         prev_busy;

    function automatic int get_stat(input int i);
        case (i)
            0:       return int'(hunger);
            1:       return int'(happiness);
            2:       return int'(health);
            3:       return int'(hygiene);
            4:       return int'(energy);
            default: return int'(social);
        endcase
    endfunction

    // Events are queued when the tick or handshake happens and resolved
    // against the reference model when the DUT finishes the matching work.
    always @(negedge clk) begin
        logic [3:0] ev;
        int         exp_run;
        bit         bad;
        if (reset) begin
            sb.delete();
            for (int i = 0; i < 6; i++) m_stats[i] = 0;
            m_dead = 0; tb_cnt = 0; prev_busy = 0; busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (prev_busy && !busy) begin
                while (sb.size() > 0 && sb[0] == c_ev_decay && m_dead) void'(sb.pop_front());
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_underflow: completion seen, expected no pending work");
                end else begin
                    ev = sb.pop_front();
                    if (ev == c_ev_decay) begin
                        for (int i = 0; i < 6; i++) m_stats[i] = (m_stats[i] >= 15) ? 15 : m_stats[i] + 1;
                        m_dead  = (m_stats[0] == 15);
                        exp_run = 6;
                    end else begin
                        if (ev < 4'd6) m_stats[ev] = (m_stats[ev] > CARE_AMOUNT) ? m_stats[ev] - CARE_AMOUNT : 0;
                        exp_run = 1;
                    end
                    bad = 0;
                    for (int i = 0; i < 6; i++) if (get_stat(i) !== m_stats[i]) bad = 1;
                    if (bad) begin
                        n_fail++;
                        $display("FAIL sb_stats ev=%0d: got %0d %0d %0d %0d %0d %0d expected %0d %0d %0d %0d %0d %0d",
                                 ev, hunger, happiness, health, hygiene, energy, social,
                                 m_stats[0], m_stats[1], m_stats[2], m_stats[3], m_stats[4], m_stats[5]);
                    end
                    n_checks++;
                    if (dead !== m_dead) begin
                        n_fail++;
                        $display("FAIL sb_dead ev=%0d: got %0b expected %0b", ev, dead, m_dead);
                    end
                    n_checks++;
                    if (busy_run != exp_run) begin
                        n_fail++;
                        $display("FAIL sb_busy_len ev=%0d: got %0d expected %0d", ev, busy_run, exp_run);
                    end
                end
            end
            if (!busy) busy_run = 0;
            if (tb_cnt == TICK_DIV - 1 && !m_dead) sb.push_back(c_ev_decay);
            if (action_valid && action_ready) sb.push_back({1'b0, action_sel});
            tb_cnt    = (tb_cnt == TICK_DIV - 1) ? 0 : tb_cnt + 1;
            prev_busy = busy;
        end
    end

    // Leaves the bench at the negedge of the first cycle after reset.
    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; action_valid = 1'b0; action_sel = 3'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_care(input logic [2:0] sel, output int waited);
        @(posedge clk); #1;
        action_valid = 1'b1; action_sel = sel; waited = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (action_ready) break;
            waited++;
        end
        @(posedge clk); #1;
        action_valid = 1'b0;
        n_checks++;
        if (waited >= 64) begin
            n_fail++;
            $display("FAIL care_accept sel=%0d: got no handshake in %0d cycles expected one", sel, waited);
        end
    endtask

    task automatic wait_quiet();
        bool_loop: for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) return;
        end
        n_checks++; n_fail++;
        $display("FAIL quiet_timeout: got busy=%0b pending=%0d expected idle", busy, sb.size());
    endtask

    task automatic wait_pass();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy) break;
        end
        n_checks++;
        if (!busy) begin
            n_fail++;
            $display("FAIL pass_timeout: got busy=0 expected busy=1");
        end
        wait_quiet();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (dead !== 1'b0 || busy !== 1'b0 || action_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_flags: got dead=%0b busy=%0b ready=%0b expected 0 0 1", dead, busy, action_ready);
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (get_stat(i) !== 0) begin
                n_fail++;
                $display("FAIL reset_stat[%0d]: got %0d expected 0", i, get_stat(i));
            end
        end
    endtask

    task automatic test_first_tick();
        int busy_cnt = 0;
        do_reset();
        for (int c = 0; c <= 14; c++) begin
            if (c > 0) @(negedge clk);
            if (busy) busy_cnt++;
            if (c == 7) begin
                n_checks++;
                if (action_ready !== 1'b0 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL tick_cycle7: got ready=%0b busy=%0b expected 0 0", action_ready, busy);
                end
            end
            if (c == 8) begin
                n_checks++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL decay_start: got busy=%0b expected 1", busy);
                end
            end
        end
        n_checks++;
        if (busy_cnt != 6) begin
            n_fail++;
            $display("FAIL decay_len: got %0d expected 6", busy_cnt);
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (get_stat(i) !== 1) begin
                n_fail++;
                $display("FAIL first_pass_stat[%0d]: got %0d expected 1", i, get_stat(i));
            end
        end
    endtask

    task automatic test_care_floor();
        int w;
        do_reset();
        repeat (29) @(negedge clk);
        do_care(3'd2, w);
        n_checks++;
        if (w != 0) begin
            n_fail++;
            $display("FAIL care_wait: got %0d expected 0", w);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL care_busy: got %0b expected 1", busy);
        end
        @(negedge clk);
        n_checks++;
        if (health !== 4'd0 || hunger !== 4'd3 || happiness !== 4'd3 || hygiene !== 4'd3 ||
            energy !== 4'd3 || social !== 4'd3) begin
            n_fail++;
            $display("FAIL care_floor: got %0d %0d %0d %0d %0d %0d expected 3 3 0 3 3 3",
                     hunger, happiness, health, hygiene, energy, social);
        end
        n_checks++;
        if (action_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL pending_block: got ready=%0b busy=%0b expected 0 0", action_ready, busy);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pending_decay: got busy=%0b expected 1", busy);
        end
        wait_quiet();
    endtask

    task automatic test_tick_collision();
        int w;
        do_reset();
        repeat (6) @(negedge clk);
        do_care(3'd0, w);
        n_checks++;
        if (w != 7) begin
            n_fail++;
            $display("FAIL collision_wait: got %0d cycles expected 7", w);
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (hunger !== 4'd0 || happiness !== 4'd1) begin
            n_fail++;
            $display("FAIL collision_result: got hunger=%0d happiness=%0d expected 0 1", hunger, happiness);
        end
        wait_quiet();
    endtask

    task automatic test_death();
        bit moved = 0;
        do_reset();
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (dead) break;
        end
        n_checks++;
        if (dead !== 1'b1 || hunger !== 4'd15 || action_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL death_entry: got dead=%0b hunger=%0d ready=%0b busy=%0b expected 1 15 0 0",
                     dead, hunger, action_ready, busy);
        end
        @(posedge clk); #1;
        action_valid = 1'b1; action_sel = 3'd0;
        for (int k = 0; k < 3 * TICK_DIV; k++) begin
            @(negedge clk);
            if (busy || action_ready || !dead) moved = 1;
            for (int i = 0; i < 6; i++) if (get_stat(i) !== 15) moved = 1;
        end
        action_valid = 1'b0;
        n_checks++;
        if (moved) begin
            n_fail++;
            $display("FAIL death_frozen: got activity while dead expected frozen at 15");
        end
    endtask

    task automatic test_reset_mid_decay();
        do_reset();
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || health !== 4'd1 || hygiene !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_decay: got busy=%0b health=%0d hygiene=%0d expected 1 1 0", busy, health, hygiene);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || dead !== 1'b0 || action_ready !== 1'b1 || hunger !== 4'd0 ||
            happiness !== 4'd0 || health !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_abort: got busy=%0b dead=%0b ready=%0b h=%0d %0d %0d expected 0 0 1 0 0 0",
                     busy, dead, action_ready, hunger, happiness, health);
        end
    endtask

    task automatic test_saturation();
        int w, prev_h;
        bit ok;
        do_reset();
        for (int it = 0; it < 60; it++) begin
            if (m_stats[1] == 15 && m_stats[0] < 10) break;
            if (m_stats[0] >= 8) do_care(3'd0, w);
            else wait_pass();
            wait_quiet();
        end
        prev_h = m_stats[0];
        wait_pass();
        ok = (happiness === 4'd15) && (health === 4'd15) && (hygiene === 4'd15) &&
             (energy === 4'd15) && (social === 4'd15);
        n_checks++;
        if (!ok || hunger !== 4'(prev_h + 1)) begin
            n_fail++;
            $display("FAIL saturate: got %0d %0d %0d %0d %0d %0d expected %0d 15 15 15 15 15",
                     hunger, happiness, health, hygiene, energy, social, prev_h + 1);
        end
        do_care(3'd7, w);
        wait_quiet();
        n_checks++;
        if (hunger !== 4'(m_stats[0]) || happiness !== 4'd15 || social !== 4'd15 || dead !== 1'b0) begin
            n_fail++;
            $display("FAIL sel7_noop: got hunger=%0d happiness=%0d social=%0d dead=%0b expected %0d 15 15 0",
                     hunger, happiness, social, dead, m_stats[0]);
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d events expected 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_first_tick();
        test_care_floor();
        test_tick_collision();
        test_reset_mid_decay();
        test_saturation();
        test_death();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/needs_scheduler.md
NEEDS_SCHEDULER -- requirements
Module: needs_scheduler

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 1000000, giving clock cycles per decay tick (legal range 8 or more).
REQ-002 The block SHALL have parameter CARE_AMOUNT, default 4, giving the amount one care action removes from a stat (legal range 1..15).
REQ-003 The block SHALL have port clk, input, 1, system clock; all logic is on the rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 The block SHALL have port action_valid, input, 1, high when a care request is presented.
REQ-006 The block SHALL have port action_sel, input, 3, the target stat: 0 hunger, 1 happiness, 2 health, 3 hygiene, 4 energy, 5 social.
REQ-007 The block SHALL have port action_ready, output, 1, high when a care request can be accepted.
REQ-008 The block SHALL have ports hunger, happiness, health, hygiene, energy and social, each output, 4, the current need level (0 satisfied, 15 critical).
REQ-009 The block SHALL have port busy, output, 1, high while a decay pass or care update is in progress.
REQ-010 The block SHALL have port dead, output, 1, high when the pet is dead.

Function
REQ-011 The tick divider SHALL count 0..TICK_DIV-1 and wrap; it SHALL assert a one-cycle tick when the count equals TICK_DIV-1, in every state except DEAD.
REQ-012 The FSM SHALL have four states: IDLE, DECAY, CARE and DEAD.
REQ-013 IDLE SHALL go to DECAY on a tick or a pending tick; otherwise it SHALL go to CARE when a handshake occurs.
REQ-014 A handshake SHALL be action_valid and action_ready high in the same cycle; action_ready SHALL equal (state==IDLE) and no tick this cycle and no pending tick.
REQ-015 A tick SHALL have priority over an action in the same cycle; the action stays unaccepted and the requester holds action_valid.
REQ-016 DECAY SHALL last exactly 6 cycles, index 0..5 in order; each cycle SHALL apply a saturating +1 to stat[index], capped at 15.
REQ-017 After index 5, DECAY SHALL go to DEAD if hunger==15, otherwise to IDLE.
REQ-018 CARE SHALL last 1 cycle and apply a saturating subtract of CARE_AMOUNT (floor 0) to the stat latched at handshake, then return to IDLE.
REQ-019 An action_sel value of 6 or 7 SHALL be accepted without changing any stat.
REQ-020 A tick arriving during DECAY or CARE SHALL set a pending flag; the flag SHALL be cleared on entry to DECAY, and at most one pending tick is held (further ticks are dropped).
REQ-021 busy SHALL be high exactly when state is DECAY or CARE.
REQ-022 In DEAD, dead=1, action_ready=0, busy=0 and all stats SHALL be frozen; only reset exits DEAD.
REQ-023 All outputs SHALL be registered or decoded from state only, with no combinational path from inputs to outputs except action_ready's dependence on the tick.

Reset
REQ-024 On reset, the block SHALL set state to IDLE, divider to 0, pending to 0 and all six stats to 0.
REQ-025 In the first cycle after reset: dead=0, busy=0, action_ready=1.
REQ-026 Reset SHALL take priority in every state, including mid-DECAY, mid-CARE and DEAD, and any partial decay pass SHALL be discarded.

Structure
REQ-027 Shared package needs_pkg SHALL hold the stat index constants (HUNGER=0..SOCIAL=5), NUM_STATS=6, STAT_MAX=15 and the FSM state enum.
REQ-028 The divider SHALL be a sub-module tick_divider (clk, reset, tick), parameterised by TICK_DIV.
REQ-029 Stats SHALL be stored as a 6-entry array indexed by the needs_pkg constants.

Verification (TICK_DIV=8, CARE_AMOUNT=4)
REQ-030 Reset release with no actions for 8 cycles -> tick at cycle 7, busy high 6 cycles, all stats become 1.
REQ-031 After 3 ticks, so health=3, request action_sel=2 -> accepted, health=0 one cycle later (floor), other stats unchanged.
REQ-032 action_valid rises in the same cycle as a tick -> action_ready=0, DECAY runs first, then the action is accepted in the first IDLE cycle.
REQ-033 Preload hunger=14, then tick -> hunger=15 after the pass, dead=1, action_ready=0, and stats stay constant across 3 further TICK_DIV periods.
REQ-034 Assert reset during DECAY index 3 -> next cycle all stats=0, state IDLE, busy=0.
REQ-035 With all stats at 15 except hunger=5, run a decay pass -> the saturated stats stay at 15, and action_sel=7 is accepted with no stat change.
